// File: rtl/dfram_pkg.sv
// dfram_pkg: shared DFRAM geometry and reader FSM encoding.
// Imported by the DFRAM read-side sequencer files.
package dfram_pkg;

  localparam int DFRAM_DW     = 128;
  localparam int DFRAM_DEPTH  = 1024;
  localparam int DFRAM_AW     = $clog2(DFRAM_DEPTH);
  localparam int DFRAM_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rdr_state_e;

endpackage

// File: rtl/dfram_reader_if.sv
// dfram_reader_if: DFRAM read port plus downstream stream.
// master = reader side, slave = memory/consumer side.
interface dfram_reader_if
  import dfram_pkg::*;
#(
  parameter int DW = DFRAM_DW,
  parameter int AW = DFRAM_AW
);

  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    output rd_req, rd_addr,
    input  rd_data, rd_valid,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_data, rd_valid,
    input  m_valid, m_data, m_last,
    output m_ready
  );

endinterface

// File: rtl/dfram_rd_fifo.sv
// dfram_rd_fifo: return-beat FIFO with a registered head entry.
// o_count includes the head register.
module dfram_rd_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNW  = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_push,
  input  logic [DW-1:0]  i_din,
  input  logic           i_pop,
  output logic [DW-1:0]  o_dout,
  output logic [CNW-1:0] o_count,
  output logic           o_full,
  output logic           o_empty
);

  logic [DW-1:0]  r_mem [DEPTH];
  logic [PW-1:0]  r_wp;
  logic [PW-1:0]  r_rp;
  logic [CNW-1:0] r_mcnt;
  logic           r_vld;
  logic [DW-1:0]  r_head;

  logic w_pop;
  logic w_mem_empty;
  logic w_to_head;
  logic w_wr;
  logic w_rd;

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop       = i_pop && r_vld;
  assign w_mem_empty = (r_mcnt == '0);
  // bypass storage when the head is free or drains this cycle
  assign w_to_head   = !r_vld || (w_pop && w_mem_empty);
  assign w_wr        = i_push && !w_to_head;
  assign w_rd        = w_pop && !w_mem_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_mcnt <= '0;
      r_vld  <= 1'b0;
      r_head <= '0;
    end else begin
      if (w_wr) r_wp <= f_inc(r_wp);
      if (w_rd) r_rp <= f_inc(r_rp);
      r_mcnt <= r_mcnt + CNW'(w_wr) - CNW'(w_rd);
      if (w_rd)
        r_head <= r_mem[r_rp];
      else if (i_push && w_to_head)
        r_head <= i_din;
      if (w_rd || (i_push && w_to_head))
        r_vld <= 1'b1;
      else if (w_pop)
        r_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_din;
  end

  assign o_dout  = r_head;
  assign o_count = r_mcnt + CNW'(r_vld);
  assign o_full  = (o_count == CNW'(DEPTH));
  assign o_empty = !r_vld;

endmodule

// File: rtl/dfram_reader.sv
// dfram_reader: burst read sequencer from DFRAM into an
// in-order valid/ready stream, credit-limited by the FIFO.
module dfram_reader
  import dfram_pkg::*;
#(
  parameter int DW         = DFRAM_DW,
  parameter int DEPTH      = DFRAM_DEPTH,
  parameter int AW         = $clog2(DEPTH),
  parameter int RD_LAT     = DFRAM_RD_LAT,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] len,
  output logic          busy,
  output logic          done,
  dfram_reader_if.master bus
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int IW  = $clog2(RD_LAT + 2);
  localparam int OW  = ((IW > FCW) ? IW : FCW) + 2;

  rdr_state_e r_state;
  rdr_state_e w_state_nxt;

  logic [CW-1:0] r_len;
  logic [CW-1:0] r_issued;
  logic [CW-1:0] r_acc;
  logic [AW-1:0] r_addr;
  logic [IW-1:0] r_inflight;
  logic          r_rd_req;
  logic          r_busy;
  logic          r_done;
  logic          r_last;

  logic           w_push;
  logic           w_hs;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [FCW-1:0] w_fifo_cnt;
  logic [DW-1:0]  w_fifo_dout;

  logic           w_go;
  logic           w_zero;
  logic           w_last_hs;
  logic           w_issue;
  logic           w_done_nxt;
  logic [OW-1:0]  w_occ;
  logic [FCW-1:0] w_cnt_nxt;
  logic [CW-1:0]  w_acc_nxt;

  function automatic logic [AW-1:0] f_wrap(
    input logic [AW-1:0] a
  );
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign w_go   = (r_state == IDLE) && start;
  assign w_zero = (len == '0);
  assign w_hs   = !w_fifo_empty && bus.m_ready;
  assign w_push = bus.rd_valid && (r_state != IDLE)
                  && !w_fifo_full;
  assign w_last_hs = w_hs && (r_state != IDLE)
                     && (r_acc == r_len - CW'(1));

  // r_rd_req is a request DFRAM samples this edge; a beat
  // leaving this edge frees its slot
  assign w_occ = OW'(r_inflight) + OW'(r_rd_req)
               + OW'(w_fifo_cnt) - OW'(w_hs);

  assign w_cnt_nxt = w_fifo_cnt + FCW'(w_push)
                   - FCW'(w_hs);
  assign w_acc_nxt = r_acc + CW'(w_hs);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (start && !w_zero)
          w_state_nxt = (len == CW'(1)) ? DRAIN : ISSUE;
      ISSUE:
        if (w_issue && (r_issued + CW'(1) == r_len))
          w_state_nxt = DRAIN;
      DRAIN:
        if (w_last_hs) w_state_nxt = IDLE;
      default:
        w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_issue    = 1'b0;
    w_done_nxt = w_last_hs;
    unique case (r_state)
      IDLE: begin
        w_issue    = start && !w_zero;
        w_done_nxt = start && w_zero;
      end
      ISSUE:
        w_issue = (r_issued < r_len)
                  && (w_occ < OW'(FIFO_DEPTH));
      default: w_issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_issued   <= '0;
      r_acc      <= '0;
      r_addr     <= '0;
      r_inflight <= '0;
      r_rd_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_rd_req   <= w_issue;
      r_done     <= w_done_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_inflight <= r_inflight + IW'(r_rd_req)
                  - IW'(w_push);
      if (w_go) begin
        r_len    <= len;
        r_acc    <= '0;
        r_issued <= w_zero ? '0 : CW'(1);
        r_addr   <= base_addr;
      end else begin
        if (w_issue) r_issued <= r_issued + CW'(1);
        if (w_issue) r_addr   <= f_wrap(r_addr);
        if (w_hs)    r_acc    <= w_acc_nxt;
      end
      r_last <= (w_cnt_nxt != '0)
                && (w_acc_nxt == r_len - CW'(1))
                && (w_state_nxt != IDLE);
    end
  end

  dfram_rd_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (bus.rd_data),
    .i_pop   (w_hs),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_cnt),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign bus.rd_req  = r_rd_req;
  assign bus.rd_addr = r_addr;
  assign bus.m_valid = !w_fifo_empty;
  assign bus.m_data  = w_fifo_dout;
  assign bus.m_last  = r_last;

endmodule

// File: tb/tb_dfram_reader.sv
// tb_dfram_reader: scoreboard bench for dfram_reader with a
// fixed-latency DFRAM model holding mem[i] = i.
module tb_dfram_reader;

  localparam int DW = 128;
  localparam int AW = 10;
  localparam int CW = 11;
  localparam int MD = 1024;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] len;
  logic          busy;
  logic          done;

  dfram_reader_if #(.DW(DW), .AW(AW)) bus ();

  dfram_reader u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  // DFRAM model, two-cycle read latency
  logic          pv0 = 1'b0;
  logic          pv1 = 1'b0;
  logic [AW-1:0] pa0 = '0;
  logic [AW-1:0] pa1 = '0;
  always @(posedge clk) begin
    pv0 <= bus.rd_req;
    pa0 <= bus.rd_addr;
    pv1 <= pv0;
    pa1 <= pa0;
  end
  assign bus.rd_valid = pv1;
  assign bus.rd_data  = DW'(pa1);

  int rdy_mode = 1;
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.m_ready = 1'b0;
        2:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b1;
      endcase
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  logic [AW-1:0]  addr_q [$];
  logic [DW-1:0]  exp_d  [$];
  bit             exp_l  [$];

  int   t_start   = 0;
  int   first_mv  = -1;
  int   last_rel  = -1;
  int   done_rel  = -1;
  bit   done_seen = 1'b0;
  bit   busy_done = 1'b0;
  int   req_cnt   = 0;
  int   busy_cnt  = 0;
  int   beats     = 0;
  int   outst     = 0;
  int   max_outst = 0;
  bit   post_rst  = 1'b0;
  int   mv_post   = 0;
  bit   stall_p   = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  always @(negedge clk) begin
    int rel;
    if (!rst_n) begin
      outst   = 0;
      stall_p = 1'b0;
    end else begin
      rel = ncyc - t_start + 1;
      if (bus.rd_req) begin
        req_cnt++;
        outst++;
        if (addr_q.size() > 0)
          chk("addr", 128'(bus.rd_addr), 128'(addr_q.pop_front()));
        else
          chk("addr_extra", 128'(bus.rd_addr), 128'(MD));
      end
      if (busy) busy_cnt++;
      if (bus.m_valid && first_mv < 0) first_mv = rel;
      if (bus.m_valid && stall_p) begin
        chk("hold_d", bus.m_data, prev_d);
        chk("hold_l", 128'(bus.m_last), 128'(prev_l));
      end
      stall_p = bus.m_valid && !bus.m_ready;
      prev_d  = bus.m_data;
      prev_l  = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        beats++;
        outst--;
        if (exp_d.size() > 0) begin
          chk("data", bus.m_data, exp_d.pop_front());
          chk("last", 128'(bus.m_last), 128'(exp_l.pop_front()));
        end else begin
          chk("beat_extra", bus.m_data, '1);
        end
        if (bus.m_last) last_rel = rel;
      end
      if (outst > max_outst) max_outst = outst;
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_rel  = rel;
        busy_done = busy;
      end
      if (bus.rd_valid)
        chk("ovf", 128'(u_dut.w_fifo_full), 128'(0));
      if (post_rst && bus.m_valid) mv_post++;
    end
  end

  task automatic go(input int b, input int l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    len       = CW'(l);
    done_seen = 1'b0;
    first_mv  = -1;
    last_rel  = -1;
    done_rel  = -1;
    req_cnt   = 0;
    busy_cnt  = 0;
    beats     = 0;
    for (int i = 0; i < l; i++) begin
      addr_q.push_back(AW'((b + i) % MD));
      exp_d.push_back(DW'((b + i) % MD));
      exp_l.push_back(i == l - 1);
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    t_start = ncyc;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done_seen && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (!done_seen) chk("done_timeout", 128'(0), 128'(1));
  endtask

  task automatic chk_idle_outs(input string tag);
    chk(tag, {bus.m_data, busy, done, bus.rd_req,
              bus.rd_addr, bus.m_valid, bus.m_last}[127:0],
        128'(0));
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outs("reset");
    chk("reset_data", bus.m_data, 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    go(5, 8);
    wait_done(100);
    chk("t1_first_mv", 128'(first_mv), 128'(4));
    chk("t1_last_cyc", 128'(last_rel), 128'(11));
    chk("t1_done_cyc", 128'(done_rel), 128'(12));
    chk("t1_busy_done", 128'(busy_done), 128'(0));
    chk("t1_beats", 128'(beats), 128'(8));

    go(1020, 8);
    wait_done(100);
    chk("t2_beats", 128'(beats), 128'(8));

    go(77, 0);
    wait_done(20);
    chk("t3_done_cyc", 128'(done_rel), 128'(1));
    chk("t3_req", 128'(req_cnt), 128'(0));
    chk("t3_busy", 128'(busy_cnt), 128'(0));

    rdy_mode = 2;
    go(37, 16);
    wait_done(400);
    chk("t4_beats", 128'(beats), 128'(16));

    rdy_mode = 0;
    go(200, 10);
    repeat (20) @(posedge clk);
    chk("t6_req_stall", 128'(req_cnt), 128'(4));
    chk("t6_beats_stall", 128'(beats), 128'(0));
    rdy_mode = 1;
    wait_done(200);
    chk("t6_req", 128'(req_cnt), 128'(10));
    chk("t6_beats", 128'(beats), 128'(10));

    go(100, 8);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(500);
    len       = CW'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (beats < 3 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t5_beat3", 128'(beats), 128'(3));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    addr_q.delete();
    exp_d.delete();
    exp_l.delete();
    @(negedge clk);
    chk_idle_outs("t5_rst");
    chk("t5_state", 128'(u_dut.r_state), 128'(0));
    post_rst = 1'b1;
    repeat (6) @(posedge clk);
    post_rst = 1'b0;
    chk("t5_late_drop", 128'(mv_post), 128'(0));
    go(0, 2);
    wait_done(50);
    chk("t5_beats", 128'(beats), 128'(2));

    repeat (3) @(posedge clk);
    chk("max_outst_ok", 128'(max_outst <= 4), 128'(1));
    chk("sb_left", 128'(exp_d.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
